// File: rtl/keypad_time_entry.sv
// Keypad MM:SS entry stage for the microwave timer chain.
// Shifts BCD digits in, validates on start, strobes the counters' load.
module keypad_time_entry #(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic                  start,
  input  logic                  cancel,
  input  logic                  done,
  output logic [4*DIGITS-1:0]   data,
  output logic                  loadn,
  output logic [2:0]            ndigits,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    LOAD,
    HOLD
  } state_t;

  state_t                  state_q, state_d;
  logic [4*DIGITS-1:0]     data_q, data_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    loadn_q;
  logic                    err_q, err_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    kprev_q;

  logic key_evt;
  logic key_ok;
  logic time_ok;

  assign key_evt = sync_q[SYNC_STAGES-1] & ~kprev_q;
  assign key_ok  = key_evt && (key_code <= 4'd9)
                && (cnt_q < 3'(DIGITS));
  // Seconds tens above 5 or an all-zero time cannot be loaded.
  assign time_ok = (data_q[7:4] <= 4'd5) && (data_q != '0);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      loadn_q <= 1'b1;
      err_q   <= 1'b0;
      sync_q  <= '0;
      kprev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      loadn_q <= (state_d != LOAD);
      err_q   <= err_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], key_valid};
      kprev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cancel) begin
          data_d = '0;
          cnt_d  = '0;
        end else if (key_ok) begin
          data_d  = {data_q[4*DIGITS-5:0], key_code};
          cnt_d   = cnt_q + 3'd1;
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        if (cancel) begin
          state_d = IDLE;
          data_d  = '0;
          cnt_d   = '0;
        end else if (start) begin
          if (time_ok) state_d = LOAD;
          else         err_d   = 1'b1;
        end else if (key_ok) begin
          data_d = {data_q[4*DIGITS-5:0], key_code};
          cnt_d  = cnt_q + 3'd1;
        end
      end
      LOAD: begin
        if (cancel) begin
          state_d = IDLE;
          data_d  = '0;
          cnt_d   = '0;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cancel || done) begin
          state_d = IDLE;
          data_d  = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data    = data_q;
  assign loadn   = loadn_q;
  assign ndigits = cnt_q;
  assign busy    = (state_q == HOLD);
  assign err     = err_q;

endmodule
